ahb3lite_sram_slave: RTL and testbench
======================================

// Module: ahb3lite_sram_slave
// PURPOSE
//  AHB3-Lite slave: word-organised on-chip memory with programmable wait states and byte-lane writes.
//  Counterpart of the team's AHB3-Lite master BFM; sits behind the decoder/mux on an AHB3-Lite bus.
//  Serves as the synthesizable responder for BFM-driven benches and as a scratch RAM in subsystems.
// PARAMETERS
//  HADDR_SIZE   16  address width
//  HDATA_SIZE   32  data width; must be 32, 64 or 128
//  DEPTH        256 memory depth in HDATA_SIZE words
//  WAIT_STATES  0   HREADYOUT=0 cycles inserted per data phase (0..15)
// PORTS
//  HCLK       in   1               bus clock, all logic on rising edge
//  HRESET     in   1               asynchronous, active-high reset
//  HSEL       in   1               slave select
//  HADDR      in   HADDR_SIZE      byte address
//  HWDATA     in   HDATA_SIZE      write data (data phase)
//  HRDATA     out  HDATA_SIZE      read data (data phase)
//  HWRITE     in   1               1=write, 0=read
//  HSIZE      in   HSIZE_SIZE      transfer size (ahb3lite_pkg encoding)
//  HBURST     in   HBURST_SIZE     ignored; each beat addressed by HADDR
//  HPROT      in   HPROT_SIZE      ignored
//  HTRANS     in   HTRANS_SIZE     IDLE/BUSY/NONSEQ/SEQ
//  HMASTLOCK  in   1               ignored
//  HREADY     in   1               bus-level ready (address phase qualifier)
//  HREADYOUT  out  1               this slave's ready
//  HRESP      out  1               HRESP_OKAY / HRESP_ERROR
// BEHAVIOUR
//  - Reset (HRESET=1, async): HREADYOUT=1, HRESP=OKAY, HRDATA=0, FSM=IDLE, wait counter=0, pending write
//    dropped. Memory contents are not cleared. Reset mid-transfer aborts it; no partial write.
//  - Accept: HSEL & HREADY & HTRANS in {NONSEQ,SEQ} at a rising edge latches addr, size, write.
//    IDLE/BUSY/unselected: no access; next data phase OKAY, zero wait.
//  - Word index = HADDR[log2(HDATA_SIZE/8) +: log2(DEPTH)]; byte enables from HADDR low bits + HSIZE.
//  - FSM: IDLE -> (accept, WAIT_STATES>0) WAIT | (accept, WAIT_STATES=0) DATA.
//    WAIT: HREADYOUT=0, counter counts WAIT_STATES down to 1, then -> DATA.
//    DATA: HREADYOUT=1, HRESP=OKAY; on the same edge a new accept -> WAIT/DATA again, else -> IDLE.
//    Back-to-back zero-wait transfers run at one beat per cycle.
//  - Read: array read registered at accept edge; HRDATA valid in every cycle of the data phase and
//    holds until the next read completes. Latency: data on the cycle after accept (+WAIT_STATES).
//  - Write: HWDATA sampled on the DATA-cycle edge; only the enabled byte lanes are written.
//  - Read-after-write hazard: a write committing on the same edge a read to the same word is
//    accepted is forwarded bytewise (written lanes from HWDATA, others from the array); no extra wait.
//  - Unaligned addr/size combinations are not checked; lanes are taken from addr low bits as is.
// CONFIGURATION
//  - AHB3LITE_SRAM_ERR_EN defined: an accepted transfer with word index >= DEPTH, or HSIZE wider than
//    HDATA_SIZE, gets a two-cycle ERROR and no memory write.
//    ERR1: HREADYOUT=0, HRESP=ERROR. ERR2: HREADYOUT=1, HRESP=ERROR. Then -> IDLE.
//    A transfer accepted on the ERR2 edge is handled normally. WAIT_STATES is not applied to errors.
//  - Not defined: index taken modulo DEPTH (upper address bits ignored), HRESP always OKAY, ERR states absent.
// TESTING
//  - Reset: HRESET pulse mid-WAIT (WAIT_STATES=2) -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; earlier data kept.
//  - WAIT_STATES=0: write word 0x10=0xDEADBEEF, then read 0x10 -> HRDATA=0xDEADBEEF 1 cycle after accept.
//  - Byte lanes: write 0x11223344 @0x20, byte write 0xAA @0x22 (HSIZE_B8) -> read 0x20 gives 0x11AA3344.
//  - RAW forwarding: zero-wait write 0xCAFEF00D @0x40 then immediate read 0x40 -> 0xCAFEF00D, no stall.
//  - WAIT_STATES=3: INCR4 read burst -> exactly 3 HREADYOUT=0 cycles per beat, 16 cycles total data phase.
//  - ERR_EN, DEPTH=256: read @0x0400 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1; a write there leaves memory unchanged.

Source files
------------

// File: rtl/ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb3lite_sram_slave
//
// AHB3-Lite slave wrapping a word-organised on-chip memory. Every transfer
// gets WAIT_STATES cycles of HREADYOUT=0 followed by one OKAY data cycle.
// Writes honour byte lanes. A read accepted on the same edge that a write
// commits to the same word sees the freshly written bytes.
//
// Optional feature macro: AHB3LITE_SRAM_ERR_EN
//   defined   : a word index beyond DEPTH, or an HSIZE wider than the data
//               bus, gets a two-cycle ERROR response and never writes memory.
//   undefined : the index wraps (upper address bits ignored), HRESP is
//               always OKAY.
//
// Parameters
//   HADDR_SIZE   address width
//   HDATA_SIZE   data width (32, 64 or 128)
//   DEPTH        memory depth in HDATA_SIZE words (power of two)
//   WAIT_STATES  HREADYOUT=0 cycles per data phase (0..15)
//
// Ports
//   HCLK, HRESET             clock, asynchronous active-high reset
//   HSEL, HADDR, HWRITE,     address phase (qualified by HREADY)
//   HSIZE, HBURST, HPROT,
//   HTRANS, HMASTLOCK, HREADY
//   HWDATA                   write data (data phase)
//   HRDATA, HREADYOUT, HRESP data phase response
// ---------------------------------------------------------------------------
package ahb3lite_pkg;
    localparam int HTRANS_SIZE = 2;
    localparam int HSIZE_SIZE  = 3;
    localparam int HBURST_SIZE = 3;
    localparam int HPROT_SIZE  = 4;

    localparam logic [HTRANS_SIZE-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HTRANS_SIZE-1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
endpackage

module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = 16,
    parameter int HDATA_SIZE  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSEL,
    input  logic [HADDR_SIZE-1:0]  HADDR,
    input  logic [HDATA_SIZE-1:0]  HWDATA,
    output logic [HDATA_SIZE-1:0]  HRDATA,
    input  logic                   HWRITE,
    input  logic [HSIZE_SIZE-1:0]  HSIZE,
    input  logic [HBURST_SIZE-1:0] HBURST,
    input  logic [HPROT_SIZE-1:0]  HPROT,
    input  logic [HTRANS_SIZE-1:0] HTRANS,
    input  logic                   HMASTLOCK,
    input  logic                   HREADY,
    output logic                   HREADYOUT,
    output logic                   HRESP
);
    localparam int BYTES    = HDATA_SIZE / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int IDX_W    = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA
`ifdef AHB3LITE_SRAM_ERR_EN
        ,
        ST_ERR1,
        ST_ERR2
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BYTES-1:0]        be_q, be_d;
    logic                    write_q, write_d;
    logic [HDATA_SIZE-1:0]   rdata_q, rdata_d;

    logic [HDATA_SIZE-1:0]   mem [DEPTH];

    logic                    ready_int;
    logic                    accept;
    logic                    mem_we;
    logic [IDX_W-1:0]        acc_idx;
    logic [BYTES-1:0]        acc_be;
    logic [HDATA_SIZE-1:0]   fwd_word;
    int                      lane_off;
    int                      lane_cnt;

`ifdef AHB3LITE_SRAM_ERR_EN
    logic                    acc_err;
    logic [HADDR_SIZE-ADDR_LSB-1:0] word_full;

    // Out of range is judged on the whole word address, not the wrapped index
    assign word_full = HADDR[HADDR_SIZE-1:ADDR_LSB];
    assign acc_err   = (32'(word_full) >= 32'(DEPTH)) || (32'(HSIZE) > 32'(ADDR_LSB));

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

    always_comb begin
        ready_int = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
        HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end
`else
    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HADDR[HADDR_SIZE-1:ADDR_LSB+IDX_W]};

    always_comb begin
        ready_int = (state_q != ST_WAIT);
        HRESP     = HRESP_OKAY;
    end
`endif

    assign HREADYOUT = ready_int;
    assign HRDATA    = rdata_q;
    assign accept    = HSEL && HREADY && ready_int &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign acc_idx   = HADDR[ADDR_LSB +: IDX_W];
    assign mem_we    = (state_q == ST_DATA) && write_q;

    // Lanes start at the address offset inside the word and span 2**HSIZE bytes,
    // clipped at the top of the word
    always_comb begin
        lane_off = int'(HADDR[ADDR_LSB-1:0]);
        lane_cnt = 1 << HSIZE;
        acc_be   = '0;
        for (int i = 0; i < BYTES; i++) begin
            acc_be[i] = (i >= lane_off) && (i < lane_off + lane_cnt);
        end
    end

    // Read data for a newly accepted read; bytes being committed on this very
    // edge to the same word come straight from HWDATA
    always_comb begin
        fwd_word = mem[acc_idx];
        for (int i = 0; i < BYTES; i++) begin
            if (mem_we && (idx_q == acc_idx) && be_q[i]) begin
                fwd_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    // Next state: finish the current data phase, then let an accepted
    // transfer override it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        be_d    = be_q;
        write_d = write_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DATA: state_d = ST_IDLE;
`ifdef AHB3LITE_SRAM_ERR_EN
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            idx_d   = acc_idx;
            be_d    = acc_be;
            write_d = HWRITE;
`ifdef AHB3LITE_SRAM_ERR_EN
            if (acc_err) begin
                state_d = ST_ERR1;
                write_d = 1'b0;
            end else
`endif
            begin
                if (WAIT_STATES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end else begin
                    state_d = ST_DATA;
                end
                if (!HWRITE) begin
                    rdata_d = fwd_word;
                end
            end
        end
    end

    // Control and read-data registers; memory contents survive reset
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    // Byte-lane write on the final data cycle; a reset aborts it
    always_ff @(posedge HCLK) begin
        if (mem_we && !HRESET) begin
            for (int i = 0; i < BYTES; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_sram_slave
//
// Two slaves share one address/data bus: dut0 with no wait states and dut3
// with three. Each has its own HSEL and sees its own HREADYOUT as HREADY.
// A pipelined master drives a queue of transfers; a byte-addressed memory
// model supplies the expected read data.
// ---------------------------------------------------------------------------
module tb_ahb3lite_sram_slave;
    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  trans;
    } xfer_t;

    logic        hclk;
    logic        hreset;
    logic        hsel0, hsel3;
    logic [15:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hrdata0, hrdata3;
    logic        hreadyout0, hreadyout3;
    logic        hresp0, hresp3;

    int          tests_run    = 0;
    int          tests_failed = 0;
    bit [7:0]    model [2][1024];
    xfer_t       xq [$];

    ahb3lite_sram_slave #(
        .HADDR_SIZE(16), .HDATA_SIZE(32), .DEPTH(256), .WAIT_STATES(0)
    ) dut0 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr),
        .HWDATA(hwdata), .HRDATA(hrdata0), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
        .HREADY(hreadyout0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
    );

    ahb3lite_sram_slave #(
        .HADDR_SIZE(16), .HDATA_SIZE(32), .DEPTH(256), .WAIT_STATES(3)
    ) dut3 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel3), .HADDR(haddr),
        .HWDATA(hwdata), .HRDATA(hrdata3), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
        .HREADY(hreadyout3), .HREADYOUT(hreadyout3), .HRESP(hresp3)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Memory model: each byte of a write lands at address + k for the k-th
    // byte of the transfer, as long as it stays inside the 4-byte word.
    // 1024 bytes = DEPTH words, so addresses wrap like the slave's index.
    function automatic void model_write(input int sel, input logic [15:0] a,
                                        input logic [2:0] s, input logic [31:0] d);
        int off = int'(a) % 4;
        int n   = 1 << s;
        for (int k = 0; k < n; k++) begin
            if (off + k < 4) model[sel][(int'(a) + k) % 1024] = d[8*(off+k) +: 8];
        end
    endfunction

    function automatic logic [31:0] model_read(input int sel, input logic [15:0] a);
        int base = (int'(a) % 1024) & ~3;
        return {model[sel][base+3], model[sel][base+2], model[sel][base+1], model[sel][base]};
    endfunction

    function automatic bit is_err(input xfer_t x);
`ifdef AHB3LITE_SRAM_ERR_EN
        return ((int'(x.addr) / 4) >= 256) || (x.size > 3'd2);
`else
        return (x.size > 3'd7);
`endif
    endfunction

    function automatic void push(input logic [15:0] a, input logic wr, input logic [2:0] s,
                                 input logic [31:0] d, input logic [1:0] t);
        xfer_t x;
        x.addr = a; x.wr = wr; x.size = s; x.wdata = d; x.trans = t;
        xq.push_back(x);
    endfunction

    task automatic drive_addr(input int sel, input int idx);
        if (idx < xq.size()) begin
            hsel0  = (sel == 0);
            hsel3  = (sel == 1);
            haddr  = xq[idx].addr;
            hwrite = xq[idx].wr;
            hsize  = xq[idx].size;
            htrans = xq[idx].trans;
        end else begin
            hsel0  = 1'b0;
            hsel3  = 1'b0;
            htrans = 2'b00;
        end
    endtask

    // Pipelined master: runs the whole queue against one slave, checking the
    // response of every data phase cycle. Called and returns at posedge + 1.
    task automatic applyStimulus(input int sel, output int dp_cycles);
        xfer_t dp;
        bit    dp_valid = 0;
        bit    dp_err   = 0;
        int    idx      = 0;
        int    waits    = 0;
        int    guard    = 0;
        logic  rdy, resp;
        logic [31:0] rdata;
        dp_cycles = 0;
        dp = xq[0];
        drive_addr(sel, 0);
        while ((idx < xq.size() || dp_valid) && guard < 5000) begin
            guard++;
            @(negedge hclk);
            rdy   = (sel == 0) ? hreadyout0 : hreadyout3;
            resp  = (sel == 0) ? hresp0 : hresp3;
            rdata = (sel == 0) ? hrdata0 : hrdata3;
            if (dp_valid) begin
                dp_cycles++;
                checkOutput("hresp", 32'(resp), 32'(dp_err));
                if (!dp.wr && !dp_err) checkOutput("hrdata", rdata, model_read(sel, dp.addr));
                if (!rdy) begin
                    waits++;
                end else begin
                    checkOutput("wait_states", waits, dp_err ? 1 : (sel == 0 ? 0 : 3));
                    if (dp.wr && !dp_err) model_write(sel, dp.addr, dp.size, dp.wdata);
                end
            end else begin
                checkOutput("idle_ready", 32'(rdy), 32'd1);
            end
            @(posedge hclk);
            #1;
            if (rdy) begin
                dp_valid = 0;
                if (idx < xq.size()) begin
                    if (xq[idx].trans[1]) begin
                        dp       = xq[idx];
                        dp_valid = 1;
                        dp_err   = is_err(dp);
                        waits    = 0;
                    end
                    idx++;
                end
                drive_addr(sel, idx);
                hwdata = dp_valid ? dp.wdata : $urandom;
            end
        end
        if (guard >= 5000) checkOutput("timeout", 32'd0, 32'd1);
        xq.delete();
    endtask

    task automatic random_run(input int sel, input int n);
        int cyc;
        for (int i = 0; i < n; i++) begin
            int          r    = $urandom_range(0, 9);
            logic [2:0]  s    = 3'($urandom_range(0, 2));
            int          off  = $urandom_range(0, 3) & ~((1 << s) - 1);
            logic [15:0] a    = 16'($urandom_range(0, 63) * 4 + off);
            logic [1:0]  t    = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
            push(a, 1'($urandom_range(0, 1)), s, $urandom, t);
        end
        applyStimulus(sel, cyc);
    endtask

    initial begin
        int cyc;
        hsel0 = 0; hsel3 = 0; haddr = '0; hwdata = '0; hwrite = 0; hsize = 3'd2;
        hburst = 3'd0; hprot = 4'b0011; htrans = 2'b00; hmastlock = 0;
        hreset = 1'b1;
        repeat (3) @(posedge hclk);
        #1;
        checkOutput("reset_hreadyout0", 32'(hreadyout0), 32'd1);
        checkOutput("reset_hresp0", 32'(hresp0), 32'd0);
        checkOutput("reset_hrdata0", hrdata0, 32'd0);
        checkOutput("reset_hreadyout3", 32'(hreadyout3), 32'd1);
        checkOutput("reset_hresp3", 32'(hresp3), 32'd0);
        checkOutput("reset_hrdata3", hrdata3, 32'd0);
        hreset = 1'b0;
        @(posedge hclk);
        #1;

        // Known contents for words 0..63 of both memories
        for (int sel = 0; sel < 2; sel++) begin
            for (int w = 0; w < 64; w++) push(16'(w * 4), 1'b1, 3'd2, $urandom | 32'h1, 2'b10);
            applyStimulus(sel, cyc);
        end

        // Word write, idle, read back
        push(16'h0010, 1'b1, 3'd2, 32'hDEADBEEF, 2'b10);
        push(16'h0000, 1'b0, 3'd2, 32'h0, 2'b00);
        push(16'h0010, 1'b0, 3'd2, 32'h0, 2'b10);
        applyStimulus(0, cyc);

        // Byte write into lane 2 of a full word
        push(16'h0020, 1'b1, 3'd2, 32'h11223344, 2'b10);
        push(16'h0022, 1'b1, 3'd0, 32'h77AA6655, 2'b10);
        push(16'h0020, 1'b0, 3'd2, 32'h0, 2'b10);
        applyStimulus(0, cyc);

        // Read straight after a write to the same word, zero wait
        push(16'h0040, 1'b1, 3'd2, 32'hCAFEF00D, 2'b10);
        push(16'h0040, 1'b0, 3'd2, 32'h0, 2'b10);
        applyStimulus(0, cyc);
        checkOutput("raw_no_stall_cycles", cyc, 2);

        random_run(0, 150);
        random_run(1, 100);

        // INCR4 read burst with three wait states per beat
        hburst = 3'b011;
        push(16'h0030, 1'b0, 3'd2, 32'h0, 2'b10);
        push(16'h0034, 1'b0, 3'd2, 32'h0, 2'b11);
        push(16'h0038, 1'b0, 3'd2, 32'h0, 2'b11);
        push(16'h003C, 1'b0, 3'd2, 32'h0, 2'b11);
        applyStimulus(1, cyc);
        checkOutput("incr4_cycles", cyc, 16);
        hburst = 3'd0;

        // Reset in the middle of a waited write: nothing written, outputs cleared
        hsel3 = 1; haddr = 16'h0010; hwrite = 1; hsize = 3'd2; htrans = 2'b10;
        @(posedge hclk);
        #1;
        hsel3 = 0; htrans = 2'b00; hwdata = 32'h0BADF00D;
        @(negedge hclk);
        checkOutput("rst_pre_wait", 32'(hreadyout3), 32'd0);
        #2 hreset = 1'b1;
        #1;
        checkOutput("rst_hreadyout", 32'(hreadyout3), 32'd1);
        checkOutput("rst_hresp", 32'(hresp3), 32'd0);
        checkOutput("rst_hrdata", hrdata3, 32'd0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        push(16'h0010, 1'b0, 3'd2, 32'h0, 2'b10);
        applyStimulus(1, cyc);

`ifdef AHB3LITE_SRAM_ERR_EN
        for (int sel = 0; sel < 2; sel++) begin
            push(16'h0400, 1'b0, 3'd2, 32'h0, 2'b10);
            push(16'h0400, 1'b1, 3'd2, 32'h12345678, 2'b10);
            push(16'h0000, 1'b1, 3'd3, 32'h87654321, 2'b10);
            push(16'h0000, 1'b0, 3'd2, 32'h0, 2'b10);
            applyStimulus(sel, cyc);
        end
`else
        for (int sel = 0; sel < 2; sel++) begin
            push(16'h0404, 1'b1, 3'd2, 32'h5A5AA5A5, 2'b10);
            push(16'h0004, 1'b0, 3'd2, 32'h0, 2'b10);
            applyStimulus(sel, cyc);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
